fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction width in bits.
REQ-002 Parameter ADDR_WIDTH, default 11: instruction-memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hold PC and the IF/ID register.
REQ-006 branch_taken  input  1  redirect the PC to branch_target.
REQ-007 branch_target  input  ADDR_WIDTH  branch word address.
REQ-008 jump  input  1  redirect the PC to jump_target.
REQ-009 jump_target  input  ADDR_WIDTH  jump word address.
REQ-010 rom_addr  output  ADDR_WIDTH  word address driven to the instruction memory; equals current PC, combinational.
REQ-011 rom_data  input  DATA_WIDTH  instruction returned by the instruction memory, combinational read of rom_addr in the same cycle.
REQ-012 if_id_instr  output  DATA_WIDTH  registered instruction to decode.
REQ-013 if_id_pc_plus1  output  ADDR_WIDTH  registered PC+1 of if_id_instr.
REQ-014 if_id_valid  output  1  if_id_instr is a real instruction (not a bubble).
REQ-015 halted  output  1  high while the state machine is in HALTED.

Function
REQ-016 The state machine SHALL have states RUN and HALTED only.
- RUN->HALTED: an instruction with opcode bits [31:26] = 6'b111111 (HALT) is latched into IF/ID.
- HALTED->RUN: redirect only.
REQ-017 Redirect SHALL be branch_taken OR jump; when both are high, branch_target wins.
REQ-018 Per-edge priority in RUN SHALL be: redirect > stall > normal advance.
- Redirect: PC<=target; IF/ID valid<=0, instr<=0.
- Stall: PC and IF/ID unchanged.
- Advance: IF/ID<=(rom_data, PC+1, valid=1); PC<=PC+1.
REQ-019 Fetch latency SHALL be one cycle: the instruction at address A appears on if_id_instr the edge after rom_addr=A, unless that edge carries a stall or redirect.
REQ-020 PC+1 SHALL be computed modulo 2**ADDR_WIDTH: PC=2**ADDR_WIDTH-1 advances to 0 with if_id_pc_plus1=0.
REQ-021 In HALTED without redirect, the PC SHALL be frozen at the address after HALT; IF/ID SHALL hold the HALT instruction with valid=1 for exactly one cycle, then valid<=0 and instr<=0 on each subsequent edge; stall SHALL have no effect.
REQ-022 A redirect in HALTED SHALL behave as in RUN (flush, load target) and SHALL return to RUN; the flushed HALT is discarded.
REQ-023 A redirect on the same edge a HALT would be latched SHALL flush that HALT and remain in RUN.
REQ-024 Stall on the edge a HALT is presented SHALL keep RUN; HALT is latched on the first non-stalled edge.
REQ-025 halted SHALL be a registered decode of state, with no combinational path from inputs.

Reset
REQ-026 While rst_n=0, immediately and independently of clk: PC=0, rom_addr=0, if_id_instr=0, if_id_pc_plus1=0, if_id_valid=0, halted=0, state=RUN.
REQ-027 On the first rising edge after rst_n deasserts, the instruction at address 0 SHALL be latched, subject to REQ-018.
REQ-028 Reset asserted mid-operation, including in HALTED or during stall, SHALL override all other inputs.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state enum (RUN, HALTED), the HALT opcode constant 6'b111111, and the opcode field position [31:26].
REQ-030 The IF/ID register, with flush, hold and load controls, SHALL be one sub-module, if_id_reg; PC, next-PC mux and FSM stay in fetch_stage.

Verification
REQ-031 Straight-line fetch: ROM[0..3]=distinct words, no stall -> if_id_instr=ROM[0..3] on edges 1..4, if_id_pc_plus1=1..4, valid=1.
REQ-032 Stall: stall=1 for 2 cycles at PC=5 -> rom_addr stays 5, IF/ID holds ROM[4]; then ROM[5] on release.
REQ-033 Redirect: branch_taken=1, target=0x100, jump=1, jump_target=0x200 simultaneously with stall=1 -> PC=0x100, valid=0 next cycle, ROM[0x100] the cycle after.
REQ-034 Wrap: PC=0x7FF advance -> PC=0, if_id_pc_plus1=0.
REQ-035 HALT at address 3 -> halted=1 after latch, PC frozen at 4, valid=0 following; jump to 0x10 -> halted=0, fetch resumes at 0x10.
REQ-036 Asynchronous reset mid-run, pulsed between clock edges -> all outputs 0 without a clock edge; fetch restarts at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared fetch-stage types: FSM states and HALT opcode decode.
// Rev     : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [5:0] c_halt_opcode = 6'b111111;
  localparam int         c_opcode_msb  = 31;
  localparam int         c_opcode_lsb  = 26;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register; priority flush > hold > load.
// Rev     : 1.0
// ============================================================================
module if_id_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] instr_d,
  input  logic [ADDR_WIDTH-1:0] pc_plus1_d,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc_plus1;
  logic                  r_valid;

  // A flush leaves pc_plus1 untouched; it is meaningless without valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (!hold && load) begin
      r_instr    <= instr_d;
      r_pc_plus1 <= pc_plus1_d;
      r_valid    <= 1'b1;
    end
  end

  assign instr    = r_instr;
  assign pc_plus1 = r_pc_plus1;
  assign valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch: PC, next-PC mux, RUN/HALTED FSM, IF/ID register.
// Rev     : 1.0
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus1,
  output logic                  if_id_valid,
  output logic                  halted
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic                  r_halted;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_pc_plus1;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_redirect;
  logic                  w_is_halt;
  logic                  w_flush;
  logic                  w_hold;
  logic                  w_load;

  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? branch_target : jump_target;
  assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);
  assign w_is_halt  = (rom_data[c_opcode_msb:c_opcode_lsb] == c_halt_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_pc     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= (w_state_next == HALTED);
      r_pc     <= w_pc_next;
    end
  end

  // HALTED is entered only on the edge that actually latches the HALT word.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:     if (!w_redirect && !stall && w_is_halt) w_state_next = HALTED;
      HALTED:  if (w_redirect) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    w_flush   = 1'b0;
    w_hold    = 1'b0;
    w_load    = 1'b0;
    if (w_redirect) begin
      w_pc_next = w_target;
      w_flush   = 1'b1;
    end else if (r_state == HALTED) begin
      w_flush   = 1'b1;
    end else if (stall) begin
      w_hold    = 1'b1;
    end else begin
      w_pc_next = w_pc_plus1;
      w_load    = 1'b1;
    end
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (w_flush),
    .hold       (w_hold),
    .load       (w_load),
    .instr_d    (rom_data),
    .pc_plus1_d (w_pc_plus1),
    .instr      (if_id_instr),
    .pc_plus1   (if_id_pc_plus1),
    .valid      (if_id_valid)
  );

  assign rom_addr = r_pc;
  assign halted   = r_halted;

endmodule
`default_nettype wire
